// File: rtl/io_input_conditioner_if.sv
// Board-input bundle between the raw switch/key pins and the conditioned CPU input ports.
// No handshake: raw levels are sampled on every clock; in_port0/in_port1 are always-valid registered levels.
interface io_input_conditioner_if #(
  parameter int NSW  = 10,
  parameter int NKEY = 4
);
  logic [NSW-1:0]  sw_raw;
  logic [NKEY-1:0] key_raw;
  logic            cnt_clr;
  logic [31:0]     in_port0;
  logic [31:0]     in_port1;

  modport master (output sw_raw, key_raw, cnt_clr, input in_port0, in_port1);
  modport slave  (input sw_raw, key_raw, cnt_clr, output in_port0, in_port1);
endinterface

// File: rtl/io_input_conditioner.sv
// Switch/key conditioner: 2-flop synchroniser, per-bit stable-count debouncer,
// and 6-bit press counters per key, packed onto two 32-bit CPU input ports.
module io_input_conditioner #(
  parameter int NSW            = 10,
  parameter int NKEY           = 4,
  parameter int DEB_CYCLES     = 16,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   resetn,
  io_input_conditioner_if.slave  bus
);
  localparam int            NB       = NSW + NKEY;
  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  // Key bits sit above the switch bits; this mask is both the released-level
  // reset value of the synchroniser and the polarity flip to pressed=1.
  localparam logic [NB-1:0] KEY_MASK = {{NKEY{KEY_ACTIVE_LOW}}, {NSW{1'b0}}};

  logic [NB-1:0]   s1, s2, lvl, deb, accept;
  logic [CW-1:0]   dcnt [NB];
  logic [5:0]      pcnt [NKEY];
  logic [NKEY-1:0] key_deb, key_rise;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= KEY_MASK;
      s2 <= KEY_MASK;
    end else begin
      s1 <= {bus.key_raw, bus.sw_raw};
      s2 <= s1;
    end
  end

  assign lvl = s2 ^ KEY_MASK;

  always_comb begin
    accept = '0;
    for (int i = 0; i < NB; i++) begin
      accept[i] = (lvl[i] != deb[i]) && (dcnt[i] == CNT_MAX);
    end
  end

  // Any cycle where the synchronised level matches the accepted one restarts the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      deb <= deb ^ accept;
      for (int i = 0; i < NB; i++) begin
        if ((lvl[i] == deb[i]) || accept[i]) dcnt[i] <= '0;
        else                                 dcnt[i] <= dcnt[i] + CW'(1);
      end
    end
  end

  assign key_deb  = deb[NB-1:NSW];
  assign key_rise = accept[NB-1:NSW] & lvl[NB-1:NSW];

  // Clear has priority, so a press accepted on the clear edge is dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NKEY; k++) pcnt[k] <= '0;
    end else if (bus.cnt_clr) begin
      for (int k = 0; k < NKEY; k++) pcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NKEY; k++) begin
        if (key_rise[k]) pcnt[k] <= pcnt[k] + 6'd1;
      end
    end
  end

  assign bus.in_port0 = 32'(deb[NSW-1:0]);
  assign bus.in_port1 = {pcnt[3], pcnt[2], pcnt[1], pcnt[0], 4'b0000, key_deb};
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEB_CYCLES=4 (accept 6 edges after a raw step).
module tb_io_input_conditioner;
  logic clock;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  io_input_conditioner_if #(.NSW(10), .NKEY(4)) bus ();

  io_input_conditioner #(
    .NSW(10), .NKEY(4), .DEB_CYCLES(4), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; return 1 time unit later, away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Key pressed = raw 0; hold long enough for acceptance (6 edges) plus margin.
  task automatic press_release(input int k);
    bus.key_raw[k] = 1'b0;
    tick(7);
    bus.key_raw[k] = 1'b1;
    tick(7);
  endtask

  initial begin
    // 1: reset with all switches up and all keys pressed
    resetn      = 1'b0;
    bus.sw_raw  = 10'h3FF;
    bus.key_raw = 4'h0;
    bus.cnt_clr = 1'b0;
    tick(3);
    chk("reset_port0", bus.in_port0, 32'h0);
    chk("reset_port1", bus.in_port1, 32'h0);
    bus.sw_raw  = 10'h000;
    bus.key_raw = 4'hF;
    tick(1);
    resetn = 1'b1;
    tick(3);
    chk("post_reset_port0", bus.in_port0, 32'h0);

    // 2: exact latency of a clean switch step
    bus.sw_raw = 10'h2A5;
    tick(5);
    chk("latency_edge5", bus.in_port0, 32'h0);
    tick(1);
    chk("latency_edge6", bus.in_port0, 32'h2A5);

    // 3: key0 bounces with 2-cycle pulses, then holds pressed
    for (int seg = 0; seg < 10; seg++) begin
      bus.key_raw[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    chk("bounce_filtered", bus.in_port1, 32'h0);
    bus.key_raw[0] = 1'b0;
    tick(5);
    chk("bounce_edge5", bus.in_port1, 32'h0);
    tick(1);
    chk("bounce_edge6", bus.in_port1, 32'h0000_0101);
    bus.key_raw[0] = 1'b1;
    tick(7);
    chk("release_no_count", bus.in_port1, 32'h0000_0100);

    // 4: key3 counter wraps 63 -> 0
    for (int n = 0; n < 63; n++) press_release(3);
    chk("cnt3_63", bus.in_port1, 32'hFC00_0100);
    press_release(3);
    chk("cnt3_wrap", bus.in_port1, 32'h0000_0100);
    bus.key_raw[3] = 1'b0;
    tick(7);
    chk("cnt3_65th", bus.in_port1, 32'h0400_0108);
    bus.key_raw[3] = 1'b1;
    tick(7);
    chk("cnt3_release", bus.in_port1, 32'h0400_0100);

    // 5: clear on the edge key1 is accepted
    bus.key_raw[1] = 1'b0;
    tick(5);
    chk("clr_race_before", bus.in_port1, 32'h0400_0100);
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    chk("clr_race_edge", bus.in_port1, 32'h0000_0002);
    bus.key_raw[1] = 1'b1;
    tick(7);
    chk("clr_release", bus.in_port1, 32'h0);
    bus.key_raw[1] = 1'b0;
    tick(7);
    chk("clr_next_press", bus.in_port1, 32'h0000_4002);
    bus.key_raw[1] = 1'b1;
    tick(7);

    // 6: reset in the middle of a sw[0] debounce
    bus.sw_raw = 10'h000;
    tick(7);
    chk("sw_cleared", bus.in_port0, 32'h0);
    bus.sw_raw = 10'h001;
    tick(2);
    resetn = 1'b0;
    tick(2);
    chk("midreset_port0", bus.in_port0, 32'h0);
    chk("midreset_port1", bus.in_port1, 32'h0);
    resetn = 1'b1;
    tick(5);
    chk("midreset_edge5", bus.in_port0, 32'h0);
    tick(1);
    chk("midreset_edge6", bus.in_port0, 32'h1);
    chk("midreset_port1_quiet", bus.in_port1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
